wb_stage: RTL and testbench

//  Writeback stage directly downstream of the MEM stage. Holds the MEM/WB pipeline register and selects
//  the result (ALU, load, atomic, link). Drives the register-file write port and the WB->EX bypass.

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage.sv | 140 ++++++++++++++
 tb/tb_wb_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Types shared by the writeback stage and its neighbours: decoded-op view, WB FSM states, result sources.
package wb_stage_pkg;

  localparam int INST_RD_W = 5;

  typedef struct packed {
    logic [INST_RD_W-1:0] rd;
    logic                 writes_rd;
    logic                 is_load;
    logic                 is_atomic;
    logic                 is_jump;
  } decoded_inst_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_TRAP  = 2'd1,
    S_FLUSH = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_LOAD   = 2'd1,
    WB_ATOMIC = 2'd2,
    WB_LINK   = 2'd3
  } wb_sel_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, register-file write/bypass,
// trap commit handshake with one-cycle flush, and the retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  decoded_inst_t        mem_inst,
  input  logic [XLEN-1:0]      mem_pc,
  input  logic [XLEN-1:0]      mem_ex_data,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic [XLEN-1:0]      mem_atomic_res,
  input  logic                 mem_is_bubble,
  input  logic                 mem_trapped,
  input  logic [XLEN-1:0]      mem_trap_cause,
  input  logic [XLEN-1:0]      mem_trap_val,
  input  logic                 mem_advance,
  output logic                 wb_stall,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 trap_valid,
  input  logic                 trap_ready,
  output logic [XLEN-1:0]      trap_pc,
  output logic [XLEN-1:0]      trap_cause,
  output logic [XLEN-1:0]      trap_val,
  output logic                 wb_flush,
  output logic [63:0]          instret
);

  wb_state_t       state_q, state_next;
  decoded_inst_t   inst_p0;
  logic [XLEN-1:0] pc_p0, ex_data_p0, rdata_p0, atomic_res_p0, cause_p0, tval_p0;
  logic            trapped_p0, vld_p0;
  logic            capture;
  wb_sel_t         sel;
  logic [XLEN-1:0] result;
  logic            count_en;
  logic [63:0]     instret_q, instret_next;

  assign capture = mem_advance && !wb_stall;

  // MEM -> WB register; a trapped op stays resident while the CSR handshake runs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0        <= 1'b0;
      inst_p0       <= '0;
      pc_p0         <= '0;
      ex_data_p0    <= '0;
      rdata_p0      <= '0;
      atomic_res_p0 <= '0;
      trapped_p0    <= 1'b0;
      cause_p0      <= '0;
      tval_p0       <= '0;
    end else if (capture) begin
      vld_p0        <= !mem_is_bubble;
      inst_p0       <= mem_inst;
      pc_p0         <= mem_pc;
      ex_data_p0    <= mem_ex_data;
      rdata_p0      <= mem_rdata;
      atomic_res_p0 <= mem_atomic_res;
      trapped_p0    <= mem_trapped;
      cause_p0      <= mem_trap_cause;
      tval_p0       <= mem_trap_val;
    end else if (state_q != S_TRAP) begin
      vld_p0 <= 1'b0;
    end
  end

  always_comb begin
    sel = WB_ALU;
    if (inst_p0.is_atomic)    sel = WB_ATOMIC;
    else if (inst_p0.is_load) sel = WB_LOAD;
    else if (inst_p0.is_jump) sel = WB_LINK;
  end

  always_comb begin
    result = ex_data_p0;
    case (sel)
      WB_ATOMIC: result = atomic_res_p0;
      WB_LOAD:   result = rdata_p0;
      WB_LINK:   result = pc_p0 + XLEN'(4);
      default:   result = ex_data_p0;
    endcase
  end

  // The write port doubles as the WB->EX forward source
  assign rf_wen   = vld_p0 && !trapped_p0 && inst_p0.writes_rd && (inst_p0.rd != '0);
  assign rf_waddr = RF_ADDR_W'(inst_p0.rd);
  assign rf_wdata = result;

  assign trap_pc    = pc_p0;
  assign trap_cause = cause_p0;
  assign trap_val   = tval_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RUN;
    else          state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    wb_stall   = 1'b0;
    trap_valid = 1'b0;
    wb_flush   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_advance && !mem_is_bubble && mem_trapped) state_next = S_TRAP;
      end
      S_TRAP: begin
        wb_stall   = 1'b1;
        trap_valid = 1'b1;
        if (trap_ready) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        wb_stall   = 1'b1;
        wb_flush   = 1'b1;
        state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  assign count_en     = vld_p0 && !trapped_p0 && (state_q == S_RUN);
  assign instret_next = count_en ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_next;
  end

  assign instret = instret_q;

  // Hazard unit must hold MEM while WB is stalled
  assert property (@(posedge clk) disable iff (!reset_n) !(mem_advance && wb_stall));

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  decoded_inst_t mem_inst;
  logic [63:0]   mem_pc, mem_ex_data, mem_rdata, mem_atomic_res, mem_trap_cause, mem_trap_val;
  logic          mem_is_bubble, mem_trapped, mem_advance, trap_ready;
  logic          wb_stall, rf_wen, trap_valid, wb_flush;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata, trap_pc, trap_cause, trap_val, instret;

  wb_stage #(.XLEN(64), .RF_ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .mem_inst(mem_inst), .mem_pc(mem_pc),
    .mem_ex_data(mem_ex_data), .mem_rdata(mem_rdata), .mem_atomic_res(mem_atomic_res),
    .mem_is_bubble(mem_is_bubble), .mem_trapped(mem_trapped), .mem_trap_cause(mem_trap_cause),
    .mem_trap_val(mem_trap_val), .mem_advance(mem_advance), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .trap_valid(trap_valid),
    .trap_ready(trap_ready), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
    .wb_flush(wb_flush), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the op currently held in WB, the trap mode, and the retire count
  typedef struct packed {
    decoded_inst_t inst;
    logic [63:0]   pc, ex, rdata, atom, cause, tval;
    logic          trapped;
  } op_t;

  op_t         m_op = '0;
  bit          m_valid = 0;
  int          m_mode = 0;  // 0 running, 1 trap offered, 2 flushing
  logic [63:0] m_instret = '0;
  int          m_next_mode;
  bit          m_stalled;
  bit          started = 0;
  logic [63:0] exp_wdata;
  bit          exp_wen;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_op = '0; m_valid = 0; m_mode = 0; m_instret = '0;
    end else begin
      m_stalled = (m_mode != 0);
      if (m_valid && !m_op.trapped && m_mode == 0) m_instret = m_instret + 64'd1;
      m_next_mode = m_mode;
      if (m_mode == 0 && mem_advance && !mem_is_bubble && mem_trapped) m_next_mode = 1;
      else if (m_mode == 1 && trap_ready) m_next_mode = 2;
      else if (m_mode == 2) m_next_mode = 0;
      if (mem_advance && !m_stalled) begin
        m_op = '{inst: mem_inst, pc: mem_pc, ex: mem_ex_data, rdata: mem_rdata,
                 atom: mem_atomic_res, cause: mem_trap_cause, tval: mem_trap_val,
                 trapped: mem_trapped};
        m_valid = !mem_is_bubble;
      end else if (m_mode != 1) begin
        m_valid = 0;
      end
      m_mode = m_next_mode;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (m_op.inst.is_atomic)    exp_wdata = m_op.atom;
      else if (m_op.inst.is_load) exp_wdata = m_op.rdata;
      else if (m_op.inst.is_jump) exp_wdata = m_op.pc + 64'd4;
      else                        exp_wdata = m_op.ex;
      exp_wen = m_valid && !m_op.trapped && m_op.inst.writes_rd && (m_op.inst.rd != 5'd0);
      check("model_rf_wen", {63'd0, rf_wen}, {63'd0, exp_wen});
      check("model_rf_waddr", {59'd0, rf_waddr}, {59'd0, m_op.inst.rd});
      check("model_rf_wdata", rf_wdata, exp_wdata);
      check("model_trap_valid", {63'd0, trap_valid}, {63'd0, m_mode == 1});
      check("model_wb_stall", {63'd0, wb_stall}, {63'd0, m_mode != 0});
      check("model_wb_flush", {63'd0, wb_flush}, {63'd0, m_mode == 2});
      check("model_trap_pc", trap_pc, m_op.pc);
      check("model_trap_cause", trap_cause, m_op.cause);
      check("model_trap_val", trap_val, m_op.tval);
      check("model_instret", instret, m_instret);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_inst = '0; mem_pc = '0; mem_ex_data = '0; mem_rdata = '0; mem_atomic_res = '0;
    mem_is_bubble = 1'b0; mem_trapped = 1'b0; mem_trap_cause = '0; mem_trap_val = '0;
    mem_advance = 1'b0;
  endtask

  // Presents one op for a single capture edge; returns #1 after that edge
  task automatic send(input logic [4:0] rd, input logic wr, input logic ld, input logic at,
                      input logic jmp, input logic [63:0] pc, input logic [63:0] ex,
                      input logic [63:0] rdata, input logic [63:0] atom, input logic bubble,
                      input logic trapped, input logic [63:0] cause, input logic [63:0] tval);
    mem_inst = '{rd: rd, writes_rd: wr, is_load: ld, is_atomic: at, is_jump: jmp};
    mem_pc = pc; mem_ex_data = ex; mem_rdata = rdata; mem_atomic_res = atom;
    mem_is_bubble = bubble; mem_trapped = trapped; mem_trap_cause = cause; mem_trap_val = tval;
    mem_advance = 1'b1;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    trap_ready = 1'b0;
    #3 reset_n = 1'b0;
    started = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_instret", instret, 64'd0);
    check("reset_rf_wen", {63'd0, rf_wen}, 64'd0);
    check("reset_trap_valid", {63'd0, trap_valid}, 64'd0);
    check("reset_wb_stall", {63'd0, wb_stall}, 64'd0);
    reset_n = 1'b1;
    step();

    // ALU op
    send(5'd5, 1, 0, 0, 0, 64'h100, 64'h1234, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    check("alu_wen", {63'd0, rf_wen}, 64'd1);
    check("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    check("alu_instret_before", instret, 64'd0);
    step();
    check("alu_instret_after", instret, 64'd1);
    check("alu_wen_gone", {63'd0, rf_wen}, 64'd0);

    // Loads to x0 and x7
    send(5'd0, 1, 1, 0, 0, 64'h104, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 0, 0, 64'h0, 64'h0);
    check("load_x0_wen", {63'd0, rf_wen}, 64'd0);
    step();
    check("load_x0_instret", instret, 64'd2);
    send(5'd7, 1, 1, 0, 0, 64'h108, 64'h55, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 0, 0, 64'h0, 64'h0);
    check("load_x7_wen", {63'd0, rf_wen}, 64'd1);
    check("load_x7_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    step();

    // JAL link and atomic
    send(5'd1, 1, 0, 0, 1, 64'h8000_0000, 64'h77, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    check("jal_wdata", rf_wdata, 64'h8000_0004);
    send(5'd3, 1, 0, 1, 0, 64'h8000_0004, 64'h5555, 64'h6666, 64'h0, 0, 0, 64'h0, 64'h0);
    check("amo_wdata", rf_wdata, 64'h0);
    check("amo_wen", {63'd0, rf_wen}, 64'd1);
    step();
    check("amo_instret", instret, 64'd5);

    // Bubble advancing: nothing written, nothing retired
    send(5'd6, 1, 0, 0, 0, 64'h200, 64'h9, 64'h0, 64'h0, 1, 0, 64'h0, 64'h0);
    check("bubble_wen", {63'd0, rf_wen}, 64'd0);
    step();
    check("bubble_instret", instret, 64'd5);

    // Trap held for four cycles (ready low for three)
    send(5'd9, 1, 0, 0, 0, 64'h300, 64'h1, 64'h0, 64'h0, 0, 1, 64'd2, 64'hDEAD);
    for (int i = 0; i < 3; i++) begin
      check("trap_valid_wait", {63'd0, trap_valid}, 64'd1);
      check("trap_stall_wait", {63'd0, wb_stall}, 64'd1);
      check("trap_rf_wen", {63'd0, rf_wen}, 64'd0);
      check("trap_cause_held", trap_cause, 64'd2);
      check("trap_val_held", trap_val, 64'hDEAD);
      step();
    end
    trap_ready = 1'b1;
    check("trap_valid_4th", {63'd0, trap_valid}, 64'd1);
    check("trap_pc_held", trap_pc, 64'h300);
    step();
    trap_ready = 1'b0;
    check("flush_on", {63'd0, wb_flush}, 64'd1);
    check("flush_stall", {63'd0, wb_stall}, 64'd1);
    check("flush_trap_valid", {63'd0, trap_valid}, 64'd0);
    step();
    check("flush_off", {63'd0, wb_flush}, 64'd0);
    check("run_stall", {63'd0, wb_stall}, 64'd0);
    check("trap_instret", instret, 64'd5);

    // Trap accepted the same cycle it is offered
    trap_ready = 1'b1;
    send(5'd2, 1, 0, 0, 0, 64'h400, 64'h1, 64'h0, 64'h0, 0, 1, 64'd5, 64'hBEEF);
    check("fast_trap_valid", {63'd0, trap_valid}, 64'd1);
    step();
    trap_ready = 1'b0;
    check("fast_flush", {63'd0, wb_flush}, 64'd1);
    step();
    check("fast_run", {63'd0, wb_stall}, 64'd0);

    // Reset while a trap is being offered
    send(5'd4, 1, 0, 0, 0, 64'h500, 64'h1, 64'h0, 64'h0, 0, 1, 64'd7, 64'h1);
    check("rst_pre_trap_valid", {63'd0, trap_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_trap_valid", {63'd0, trap_valid}, 64'd0);
    check("rst_async_instret", instret, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("rst_after_stall", {63'd0, wb_stall}, 64'd0);
    check("rst_after_trap_valid", {63'd0, trap_valid}, 64'd0);
    check("rst_after_instret", instret, 64'd0);

    // Counter wrap
    force dut.instret_next = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instret_next;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    send(5'd4, 1, 0, 0, 0, 64'h600, 64'h42, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0);
    check("wrap_wdata", rf_wdata, 64'h42);
    step();
    check("wrap_instret", instret, 64'd0);
    check("idle1_wen", {63'd0, rf_wen}, 64'd0);
    step();
    check("idle2_wen", {63'd0, rf_wen}, 64'd0);
    check("idle_instret", instret, 64'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
